regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter_pkg.sv | 12 +
 rtl/regfile_write_arbiter_fifo.sv | 51 +++++
 rtl/regfile_write_arbiter.sv | 78 +++++++
 3 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_write_arbiter_pkg: shared MIPS widths, channel indices and write-entry type.
package regfile_write_arbiter_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREG = 1 << REG_ADDR_W;
  localparam int CH_ALU = 0;
  localparam int CH_LD = 1;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wr_ent_t;
endpackage

// File: rtl/regfile_write_arbiter_fifo.sv
// regwr_fifo: small circular FIFO of register writes with a per-slot valid bit,
// exposing a one-hot mask of destination registers currently held.
module regwr_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  wr_ent_t         din_i,
  input  logic            pop_i,
  output wr_ent_t         head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [NREG-1:0] mask_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  wr_ent_t          mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    wr_q, rd_q;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  // Slot occupancy alone tells full/empty: the write slot busy means no room.
  assign full_o  = vld_q[wr_q];
  assign empty_o = !vld_q[rd_q];
  assign head_o  = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      if (push_i && !full_o) begin
        mem_q[wr_q] <= din_i;
        vld_q[wr_q] <= 1'b1;
        wr_q        <= inc(wr_q);
      end
      if (pop_i && !empty_o) begin
        vld_q[rd_q] <= 1'b0;
        rd_q        <= inc(rd_q);
      end
    end
  end
  always_comb begin
    mask_o = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i]) mask_o[mem_q[i].addr] = 1'b1;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: merges ALU and load writebacks into one register-file
// write port; loads win by default, the ALU wins once it has starved long enough.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_ready,
  input  logic                  ld_valid,
  input  logic [REG_ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0]     ld_data,
  output logic                  ld_ready,
  output logic [REG_ADDR_W-1:0] a3,
  output logic [DATA_W-1:0]     wd3,
  output logic                  sig_RegWrite,
  output logic [NREG-1:0]       pending
);
  localparam int SW = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
  logic [1:0]      push, full, empty, gnt;
  wr_ent_t         din [2];
  wr_ent_t         head [2];
  logic [NREG-1:0] mask [2];
  logic [SW-1:0]   starve_q, starve_d;
  logic            starved, gnt_alu, gnt_ld;
  wr_ent_t         sel;
  assign din[CH_ALU]  = '{addr: alu_addr, data: alu_data};
  assign din[CH_LD]   = '{addr: ld_addr, data: ld_data};
  assign push[CH_ALU] = alu_valid && !full[CH_ALU];
  assign push[CH_LD]  = ld_valid && !full[CH_LD];
  assign alu_ready    = reset || !full[CH_ALU];
  assign ld_ready     = reset || !full[CH_LD];
  assign gnt[CH_ALU]  = gnt_alu;
  assign gnt[CH_LD]   = gnt_ld;
  for (genvar c = 0; c < 2; c++) begin : g_ch
    regwr_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clock),
      .rst    (reset),
      .push_i (push[c]),
      .din_i  (din[c]),
      .pop_i  (gnt[c]),
      .head_o (head[c]),
      .full_o (full[c]),
      .empty_o(empty[c]),
      .mask_o (mask[c])
    );
  end
  always_comb begin
    starved  = starve_q == SW'(STARVE_LIMIT);
    gnt_alu  = !empty[CH_ALU] && (starved || empty[CH_LD]);
    gnt_ld   = !empty[CH_LD] && !gnt_alu;
    starve_d = (empty[CH_ALU] || gnt_alu) ? '0 : starved ? starve_q : starve_q + 1'b1;
    sel      = gnt_alu ? head[CH_ALU] : head[CH_LD];
  end
  // Writes to r0 still drain their slot but never assert the write enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q     <= '0;
      sig_RegWrite <= 1'b0;
      a3           <= '0;
      wd3          <= '0;
    end else begin
      starve_q     <= starve_d;
      sig_RegWrite <= (gnt_alu || gnt_ld) && sel.addr != '0;
      if (gnt_alu || gnt_ld) begin
        a3  <= sel.addr;
        wd3 <= sel.data;
      end
    end
  end
  assign pending = reset ? '0 :
    (mask[CH_ALU] | mask[CH_LD] | (sig_RegWrite ? NREG'(1) << a3 : '0)) & ~NREG'(1);
endmodule
